// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and the shared sink.
// Ports: req/in_data/out_ready in; gnt/sel/out_valid/out_data/busy out.
interface rr_mux_arbiter_if #(
   parameter int DATA_W = 8
);
   logic [3:0]          req;
   logic [4*DATA_W-1:0] in_data;
   logic                out_ready;
   logic [3:0]          gnt;
   logic [1:0]          sel;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic                busy;

   modport master (
      output req, in_data, out_ready,
      input  gnt, sel, out_valid, out_data, busy
   );

   modport slave (
      input  req, in_data, out_ready,
      output gnt, sel, out_valid, out_data, busy
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter driving a registered 4:1 data select.
// Ports: clk, rst (sync, active-high), bus (slave: req, in_data,
// out_ready in; gnt, sel, out_valid, out_data, busy out).
// Build option ARB_FIXED_PRIO_EN: lowest-index requester always wins.
module rr_mux_arbiter #(
   parameter int DATA_W   = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   rr_mux_arbiter_if.slave  bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] gnt_q, gnt_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;

   logic [1:0] win;
   logic       found;
   logic       out_valid;
   logic       busy;
   logic       xfer;

`ifdef ARB_FIXED_PRIO_EN
   // Scan from the top so the lowest set index is written last.
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (bus.req[k]) begin
            win   = 2'(k);
            found = 1'b1;
         end
      end
   end
`else
   logic [1:0] rr_ptr_q, rr_ptr_d;

   // Offsets 1..4 from the last winner; offset 4 wraps to rr_ptr
   // itself so a lone requester can win again.
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!found && bus.req[2'(rr_ptr_q + 2'(k))]) begin
            win   = 2'(rr_ptr_q + 2'(k));
            found = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      gnt_d      = gnt_q;
      beat_cnt_d = beat_cnt_q;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      out_valid  = 1'b0;
      busy       = 1'b0;
      xfer       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = GRANT;
               sel_d      = win;
               gnt_d      = 4'b0001 << win;
               beat_cnt_d = 4'd0;
            end
         end
         GRANT: begin
            busy      = 1'b1;
            out_valid = bus.req[sel_q];
            xfer      = out_valid && bus.out_ready;
            // A dropped request wins over a final beat: no transfer.
            if (!bus.req[sel_q] ||
                (xfer && beat_cnt_q == LAST_BEAT)) begin
               state_d    = IDLE;
               gnt_d      = 4'b0000;
               beat_cnt_d = 4'd0;
`ifndef ARB_FIXED_PRIO_EN
               rr_ptr_d   = sel_q;
`endif
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= 2'd0;
         gnt_q      <= 4'b0000;
         beat_cnt_q <= 4'd0;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr_q   <= 2'd3;
`endif
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         gnt_q      <= gnt_d;
         beat_cnt_q <= beat_cnt_d;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr_q   <= rr_ptr_d;
`endif
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.out_data  = bus.in_data[sel_q*DATA_W +: DATA_W];

endmodule
